// File: rtl/cpu_pkg.sv
// Shared CPU types: bus request opcodes and the T-state encoding used by the bus sequencer.
package cpu_pkg;

    typedef enum logic [2:0] {
        BUS_IDLE  = 3'd0,
        BUS_IF    = 3'd1,
        BUS_IF_CB = 3'd2,
        BUS_READ  = 3'd3,
        BUS_WRITE = 3'd4
    } bus_opcode_t;

    typedef enum logic [1:0] {
        T1 = 2'b00,
        T2 = 2'b01,
        T3 = 2'b10,
        T4 = 2'b11
    } t_state_t;

    // Encodings 5..7 are reserved and behave as an idle M-cycle.
    function automatic bus_opcode_t decode_bus_op(input logic [2:0] raw);
        bus_opcode_t op;
        case (raw)
            3'd1:    op = BUS_IF;
            3'd2:    op = BUS_IF_CB;
            3'd3:    op = BUS_READ;
            3'd4:    op = BUS_WRITE;
            default: op = BUS_IDLE;
        endcase
        return op;
    endfunction

    function automatic logic is_read_op(input bus_opcode_t op);
        return (op == BUS_IF) || (op == BUS_IF_CB) || (op == BUS_READ);
    endfunction

endpackage

// File: rtl/cpu_bus_unit.sv
// Memory-bus sequencer: runs the four-T-state M-cycle, drives memory strobes,
// and captures fetched opcodes into IR and read data into the data latch.
module cpu_bus_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_W     = 16,
    parameter int          DATA_W     = 8,
    parameter int          WAIT_LIMIT = 255,
    parameter logic [7:0]  RESET_IR   = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        bus_op,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        ir,
    output logic              ir_cb,
    output logic              ir_load,
    output logic [DATA_W-1:0] data_in,
    output logic [1:0]        t_state,
    output logic              m_cycle_end,
    output logic              bus_timeout
);

    localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(WAIT_LIMIT);

    t_state_t          t_state_r;
    t_state_t          t_next_s;
    bus_opcode_t       op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic [CNT_W-1:0]  wait_next_s;
    logic [7:0]        ir_r;
    logic              ir_cb_r;
    logic [DATA_W-1:0] data_in_r;
    logic              timeout_r;
    logic              leave_t3_s;
    logic              forced_s;
    logic [DATA_W-1:0] byte_s;

    // Next T-state, wait counter and T3-exit / forced-completion decode.
    always_comb begin
        t_next_s    = t_state_r;
        wait_next_s = wait_cnt_r;
        leave_t3_s  = 1'b0;
        forced_s    = 1'b0;
        case (t_state_r)
            T1: t_next_s = T2;
            T2: t_next_s = T3;
            T3: begin
                if ((op_r == BUS_IDLE) || mem_ready) begin
                    t_next_s   = T4;
                    leave_t3_s = 1'b1;
                end else if (wait_cnt_r == WAIT_MAX) begin
                    t_next_s   = T4;
                    leave_t3_s = 1'b1;
                    forced_s   = 1'b1;
                end else begin
                    wait_next_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            T4:      t_next_s = T1;
            default: t_next_s = T1;
        endcase
        if (leave_t3_s) begin
            wait_next_s = {CNT_W{1'b0}};
        end else begin
            wait_next_s = wait_next_s;
        end
        byte_s = forced_s ? {DATA_W{1'b1}} : mem_rdata;
    end

    // T-state register, wait counter and timeout flag (high only in the T4 after a forced exit).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_state_r  <= T1;
            wait_cnt_r <= {CNT_W{1'b0}};
            timeout_r  <= 1'b0;
        end else begin
            t_state_r  <= t_next_s;
            wait_cnt_r <= wait_next_s;
            timeout_r  <= forced_s;
        end
    end

    // Request capture on the edge leaving T4; mem_addr only follows non-idle requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r       <= BUS_IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            mem_addr_r <= {ADDR_W{1'b0}};
        end else if (t_state_r == T4) begin
            op_r    <= decode_bus_op(bus_op);
            addr_r  <= addr_in;
            wdata_r <= wdata_in;
            if (decode_bus_op(bus_op) != BUS_IDLE) begin
                mem_addr_r <= addr_in;
            end
        end
    end

    // Data capture on the edge leaving T3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_r      <= RESET_IR;
            ir_cb_r   <= 1'b0;
            data_in_r <= {DATA_W{1'b0}};
        end else if (leave_t3_s) begin
            case (op_r)
                BUS_IF: begin
                    ir_r    <= byte_s[7:0];
                    ir_cb_r <= 1'b0;
                end
                BUS_IF_CB: begin
                    ir_r    <= byte_s[7:0];
                    ir_cb_r <= 1'b1;
                end
                BUS_READ: data_in_r <= byte_s;
                default: ;
            endcase
        end
    end

    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = wdata_r;
    assign mem_rd      = (t_state_r != T4) && is_read_op(op_r);
    assign mem_wr      = ((t_state_r == T2) || (t_state_r == T3)) && (op_r == BUS_WRITE);
    assign ir          = ir_r;
    assign ir_cb       = ir_cb_r;
    assign ir_load     = (t_state_r == T4) && ((op_r == BUS_IF) || (op_r == BUS_IF_CB));
    assign data_in     = data_in_r;
    assign t_state     = t_state_r;
    assign m_cycle_end = (t_state_r == T4);
    assign bus_timeout = timeout_r && (t_state_r == T4);

    // addr_r mirrors the latched request address; mem_addr_r is what is driven out.
    logic unused_addr_s;
    assign unused_addr_s = ^addr_r;

endmodule

// File: doc/cpu_bus_unit.md
Name: cpu_bus_unit

Overview:
- Memory-bus sequencer directly downstream of the CPU control unit.
- Consumes the per-M-cycle bus request (bus_opcode_t), the address selected by the address mux, and the outgoing data byte selected by the data_out_ctrl_t path.
- Runs the four-T-state M-cycle and drives the external memory strobes.
- Captures fetched opcodes into the instruction register (with CB-page flag) and read data into a data latch that feeds Z.

Parameters:
ADDR_W, 16, address bus width
DATA_W, 8, data bus width
WAIT_LIMIT, 255, maximum stalled T3 cycles before the access is forced to complete
RESET_IR, 8'h00, IR value after reset (NOP)

Ports:
clk  in  1  system clock, one T-state per cycle
rst  in  1  asynchronous active-high reset
bus_op  in  3  bus_opcode_t request for the next M-cycle
addr_in  in  ADDR_W  access address from the address mux
wdata_in  in  DATA_W  write byte from the register file / ALU result mux
mem_rdata  in  DATA_W  external read data
mem_ready  in  1  external ready; sampled only in T3
mem_addr  out  ADDR_W  external address
mem_wdata  out  DATA_W  external write data
mem_rd  out  1  read strobe
mem_wr  out  1  write strobe
ir  out  8  instruction register
ir_cb  out  1  IR holds a CB-page opcode
ir_load  out  1  one-cycle pulse in T4 of an IF/IF_CB M-cycle
data_in  out  DATA_W  last byte captured by a READ
t_state  out  2  current t_state_t
m_cycle_end  out  1  high during T4
bus_timeout  out  1  one-cycle pulse in T4 of a forced-completion access

Behaviour:
- Reset (asynchronous, effective immediately, including mid-access):
  - t_state=T1, op_q=IDLE, addr_q=0, wdata_q=0, wait_cnt=0.
  - ir=RESET_IR, ir_cb=0, data_in=0.
  - mem_rd=mem_wr=ir_load=bus_timeout=0; m_cycle_end=0 (T1).
  - The first M-cycle after reset release is IDLE.
- T-state sequence: T1->T2->T3->T4->T1, one clk each, except T3 may extend (wait).
- Request capture:
  - On the edge leaving T4, bus_op, addr_in and wdata_in are registered into op_q, addr_q, wdata_q.
  - Changes to these inputs at any other time are ignored.
- Outputs are decoded from registered state only (t_state, op_q, addr_q, wdata_q):
  - mem_addr=addr_q during T1..T4; it keeps its last value during IDLE M-cycles.
  - mem_wdata=wdata_q.
  - mem_rd=1 in T1,T2,T3 when op_q is IF, IF_CB or READ.
  - mem_wr=1 in T2,T3 when op_q is WRITE.
  - IDLE: no strobes, no captures, mem_ready ignored, never stalls.
- Wait states (T3, op_q != IDLE):
  - mem_ready=0 and wait_cnt<WAIT_LIMIT: stay in T3, strobes held, wait_cnt++.
  - wait_cnt==WAIT_LIMIT: proceed to T4 as if ready; the captured byte is forced to 8'hFF and bus_timeout pulses in that T4.
  - wait_cnt clears on leaving T3.
- Capture on the edge leaving T3:
  - IF: ir<=byte, ir_cb<=0.
  - IF_CB: ir<=byte, ir_cb<=1.
  - READ: data_in<=byte.
  - WRITE: no capture.
  - ir and data_in hold their values otherwise.
- ir_load=1 in T4 when op_q is IF or IF_CB. m_cycle_end=1 in every T4, including IDLE.
- Latency: the fetched opcode is visible on ir in T4 of the same M-cycle. Back-to-back M-cycles have no bubble.
- Undefined bus_op encodings (5..7) are treated as IDLE.

Decomposition:
- Add t_state_t enum to cpu_pkg: T1=2'b00, T2=2'b01, T3=2'b10, T4=2'b11.
- Reuse bus_opcode_t from cpu_pkg.
- WAIT_LIMIT stays a module parameter.
- Single module; no sub-module is warranted.

Test Plan:
- Reset, then bus_op=IF, addr_in=16'h0100, mem_rdata=8'h3E, mem_ready=1 -> first M-cycle IDLE; second M-cycle has mem_addr=0100, mem_rd high for T1..T3, ir=3E, ir_cb=0, ir_load pulse in T4, period exactly 4 clk.
- bus_op=IF_CB, mem_rdata=8'h7C -> ir=7C, ir_cb=1. A following IF with 8'h00 clears ir_cb to 0.
- bus_op=WRITE, addr_in=16'hC000, wdata_in=8'hA5 -> mem_wr high in T2,T3 only, mem_rd low throughout, mem_wdata=A5; ir and data_in unchanged.
- READ at 16'hFF44 with mem_ready low for 3 cycles in T3, mem_rdata=8'h90 -> T3 lasts 4 clk, data_in=90, M-cycle 7 clk, bus_timeout=0.
- WAIT_LIMIT=4, READ with mem_ready held low -> T3 lasts 5 clk, data_in=FF, bus_timeout pulses once in T4, next M-cycle proceeds normally.
- Assert rst during T2 of a WRITE -> mem_wr low in the same cycle, all outputs at reset values; after release, an IDLE M-cycle precedes the next request.
